// File: rtl/montgomery_mult_param_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier:
// FSM state encodings and the default operand width.
package montgomery_mult_param_pkg;

  localparam int MONT_WIDTH = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_SUB  = 2'd2
  } state_t;

endpackage

// File: rtl/montgomery_mult_param_if.sv
// Request/response bundle between the exponentiation controller (master)
// and the Montgomery multiplier (slave).
interface montgomery_mult_param_if
  import montgomery_mult_param_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, abort, in_a, in_b, in_m,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, in_a, in_b, in_m,
    output busy, done, result
  );

endinterface

// File: rtl/mont_iter_step.sv
// One radix-2 Montgomery iteration: add B when the current multiplier bit
// is set, add M when the partial sum is odd, then halve. With C < 2M and
// B, M < 2^WIDTH the (WIDTH+2)-bit sum cannot overflow.
module mont_iter_step #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH:0]   c,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  logic             a0,
  output logic [WIDTH:0]   c_next
);

  logic [WIDTH+1:0] s;
  logic [WIDTH+1:0] t;
  logic             unused_t_lsb;

  // conditional add of B, then of M to clear the LSB, then shift right
  always_comb begin
    s      = {1'b0, c} + (a0 ? {2'b00, b} : '0);
    t      = s + (s[0] ? {2'b00, m} : '0);
    c_next = t[WIDTH+1:1];
  end

  // t[0] is always zero after the odd-fixup add; it is dropped by the shift
  assign unused_t_lsb = t[0];

endmodule

// File: rtl/montgomery_mult_param.sv
// Bit-serial Montgomery multiplier: result = A*B*2^(-WIDTH) mod M.
// One iteration per clock for WIDTH clocks, then a single conditional
// final subtraction. Result is registered and held until the next done.
module montgomery_mult_param
  import montgomery_mult_param_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  montgomery_mult_param_if.slave  bus
);

  localparam int CTR_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   c_q;
  logic [WIDTH:0]   c_nxt;
  logic [CTR_W-1:0] ctr_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  logic             borrow;
  logic             unused_diff_hi;
  logic [WIDTH-1:0] diff_lo;

  mont_iter_step #(.WIDTH(WIDTH)) u_step (
    .c      (c_q),
    .b      (b_q),
    .m      (m_q),
    .a0     (a_q[0]),
    .c_next (c_nxt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; abort only matters once an operation is running
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_ITER;
      ST_ITER: begin
        if (bus.abort)                   state_nxt = ST_IDLE;
        else if (ctr_q == CTR_W'(1))     state_nxt = ST_SUB;
      end
      ST_SUB:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // final subtract C - M; the top bit is the borrow, the next bit is zero
  // whenever there is no borrow because C < 2M
  always_comb begin
    {borrow, unused_diff_hi, diff_lo} = {1'b0, c_q} - {2'b00, m_q};
  end

  // operand latch, iteration update, final result and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      ctr_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            m_q   <= bus.in_m;
            c_q   <= '0;
            ctr_q <= CTR_W'(WIDTH);
          end
        end
        ST_ITER: begin
          if (!bus.abort) begin
            c_q   <= c_nxt;
            a_q   <= a_q >> 1;
            ctr_q <= ctr_q - CTR_W'(1);
          end
        end
        ST_SUB: begin
          if (!bus.abort) begin
            result_q <= borrow ? c_q[WIDTH-1:0] : diff_lo;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Bench for the Montgomery multiplier at WIDTH=8 (directed + handshake
// corner cases) and WIDTH=512 (random odd moduli). Expected values are
// queued at launch and retired by per-DUT monitors on done.
module tb_montgomery_mult_param;
  import montgomery_mult_param_pkg::*;

  localparam int W8 = 8;
  localparam int WL = 512;

  typedef struct packed {
    logic [1023:0] pm;
    logic [511:0]  m;
  } exp_l_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  montgomery_mult_param_if #(.WIDTH(W8)) if8 ();
  montgomery_mult_param_if #(.WIDTH(WL)) ifl ();

  montgomery_mult_param #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  montgomery_mult_param #(.WIDTH(WL)) dutl (.clk(clk), .rst(rst), .bus(ifl.slave));

  logic [7:0] q8[$];
  exp_l_t     ql[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last8;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [7:0] ref8(input int a, input int b, input int m);
    int p;
    p = (a * b) % m;
    for (int r = 0; r < m; r++)
      if (((r * 256) % m) == p) return 8'(r);
    return 8'd0;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // retire 8-bit expectations on done
  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      chk("w8_done_expected", 1024'(q8.size() != 0), 1024'(1));
      if (q8.size() != 0) chk("w8_result", 1024'(if8.result), 1024'(q8.pop_front()));
    end
  end

  // retire 512-bit expectations: result*R mod M must equal A*B mod M, result < M
  always @(negedge clk) begin
    if (ifl.done === 1'b1) begin
      chk("w512_done_expected", 1024'(ql.size() != 0), 1024'(1));
      if (ql.size() != 0) begin
        exp_l_t e;
        logic [1023:0] resid;
        e = ql.pop_front();
        resid = (1024'(ifl.result) << 512) % 1024'(e.m);
        chk("w512_residue", resid, e.pm);
        chk("w512_reduced", 1024'(ifl.result < e.m), 1024'(1));
      end
    end
  end

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                         input logic [7:0] exp);
    if8.in_a = a; if8.in_b = b; if8.in_m = m; if8.start = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.in_a = 8'($urandom); if8.in_b = 8'($urandom); if8.in_m = 8'($urandom);
    chk("w8_busy_after_start", 1024'(if8.busy), 1024'(1));
  endtask

  task automatic launch_l(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
    exp_l_t e;
    e.m  = m;
    e.pm = (1024'(a) * 1024'(b)) % 1024'(m);
    ifl.in_a = a; ifl.in_b = b; ifl.in_m = m; ifl.start = 1'b1;
    ql.push_back(e);
    @(posedge clk); #1;
    ifl.start = 1'b0;
    ifl.in_a = rand512(); ifl.in_b = rand512(); ifl.in_m = rand512();
  endtask

  // lat = index of the last edge before the done cycle, counted from now
  task automatic wait_done(input bit wide, input int bound, output int lat);
    lat = -1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if ((wide ? ifl.done : if8.done) === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                     input logic [7:0] exp);
    int lat;
    @(posedge clk); #1;
    launch8(a, b, m, exp);
    wait_done(1'b0, 40, lat);
    chk("w8_latency", 1024'(lat), 1024'(W8 + 1));
    chk("w8_busy_in_done", 1024'(if8.busy), 1024'(0));
    last8 = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [7:0] m8, a8, b8;
    logic [511:0] ml, al, bl;

    rst = 1'b1;
    if8.start = 1'b0; if8.abort = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.in_m = '0;
    ifl.start = 1'b0; ifl.abort = 1'b0; ifl.in_a = '0; ifl.in_b = '0; ifl.in_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    1024'(if8.busy),   1024'(0));
    chk("rst_done",    1024'(if8.done),   1024'(0));
    chk("rst_result",  1024'(if8.result), 1024'(0));
    chk("rst_busy_l",  1024'(ifl.busy),   1024'(0));
    chk("rst_result_l", 1024'(ifl.result), 1024'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    op8(8'd5,  8'd7,  8'd13, 8'd1);
    op8(8'd12, 8'd12, 8'd13, 8'd3);
    op8(8'd0,  8'd9,  8'd13, 8'd0);
    op8(8'd9,  8'd0,  8'd13, 8'd0);
    for (int k = 0; k < 8; k++) begin
      m8 = 8'($urandom_range(1, 127) * 2 + 1);
      a8 = 8'($urandom % m8);
      b8 = 8'($urandom % m8);
      op8(a8, b8, m8, ref8(a8, b8, m8));
    end

    // second start during ITER is ignored; back-to-back start in done cycle accepted
    @(posedge clk); #1;
    launch8(8'd3, 8'd4, 8'd13, ref8(3, 4, 13));
    repeat (3) begin @(posedge clk); #1; end
    if8.in_a = 8'd1; if8.in_b = 8'd1; if8.in_m = 8'd11; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    wait_done(1'b0, 40, lat);
    chk("w8_ignored_start_latency", 1024'(lat + 4), 1024'(W8 + 1));
    launch8(8'd12, 8'd5, 8'd13, ref8(12, 5, 13));
    wait_done(1'b0, 40, lat);
    chk("w8_back_to_back_latency", 1024'(lat), 1024'(W8 + 1));
    last8 = ref8(12, 5, 13);
    repeat (15) begin @(posedge clk); #1; end
    chk("w8_queue_drained", 1024'(q8.size()), 1024'(0));

    // abort during iteration 4
    launch8(8'd7, 8'd11, 8'd13, ref8(7, 11, 13));
    repeat (3) begin @(posedge clk); #1; end
    if8.abort = 1'b1;
    void'(q8.pop_back());
    @(posedge clk); #1;
    if8.abort = 1'b0;
    chk("abort_busy",   1024'(if8.busy),   1024'(0));
    chk("abort_done",   1024'(if8.done),   1024'(0));
    chk("abort_result", 1024'(if8.result), 1024'(last8));
    repeat (15) begin @(posedge clk); #1; end
    op8(8'd7, 8'd11, 8'd13, ref8(7, 11, 13));

    // reset during iteration 3
    @(posedge clk); #1;
    launch8(8'd10, 8'd6, 8'd13, ref8(10, 6, 13));
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    void'(q8.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",   1024'(if8.busy),   1024'(0));
    chk("midrst_done",   1024'(if8.done),   1024'(0));
    chk("midrst_result", 1024'(if8.result), 1024'(0));
    repeat (15) begin @(posedge clk); #1; end
    op8(8'd10, 8'd6, 8'd13, ref8(10, 6, 13));

    // wide random operations
    for (int k = 0; k < 12; k++) begin
      ml = rand512();
      ml[0] = 1'b1;
      ml[511] = 1'b1;
      al = rand512() % ml;
      bl = rand512() % ml;
      if (k == 0) begin
        al = ml - 512'd1;
        bl = ml - 512'd1;
      end
      @(posedge clk); #1;
      launch_l(al, bl, ml);
      wait_done(1'b1, 600, lat);
      chk("w512_latency", 1024'(lat), 1024'(WL + 1));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("w512_queue_drained", 1024'(ql.size()), 1024'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
